// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: streams the fabric configuration bitstream into the fpga
// core one frame at a time, then waits a settle period before enabling the
// fabric flip-flops and reporting rdy.
// Optional build macro CFG_PARITY_EN adds an even-parity input (cfg_parity)
// that is checked on every accepted word.
module fpga_cfg_loader #(
   parameter int CFG_W         = 384,
   parameter int NUM_FRAMES    = 267,
   parameter int SETTLE_CYCLES = 10,
   parameter int CNT_W         = 9
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CFG_W-1:0]      cfg_data,
   input  logic                  cfg_valid,
   input  logic                  cfg_last,
`ifdef CFG_PARITY_EN
   input  logic                  cfg_parity,
`endif
   output logic                  cfg_ready,
   output logic [CFG_W-1:0]      configs_in,
   output logic [NUM_FRAMES-1:0] configs_en,
   output logic                  ff_en,
   output logic                  rdy,
   output logic                  busy,
   output logic [CNT_W-1:0]      frame_cnt,
   output logic                  err
);

   // Settle counter is sized so it never collapses to zero width.
   localparam int               SET_W      = $clog2(SETTLE_CYCLES + 2);
   localparam logic [SET_W-1:0] SET_LAST   = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(NUM_FRAMES - 1);
   localparam logic [NUM_FRAMES-1:0] EN_ONE = {{(NUM_FRAMES-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_SETTLE,
      S_ENABLE,
      S_DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             last_q;
   logic [SET_W-1:0] settle_cnt;
   logic             accept;
   logic             parity_ok;
   logic             start_ok;
   logic             err_set;

`ifdef CFG_PARITY_EN
   assign parity_ok = (cfg_parity == ^cfg_data);
`else
   assign parity_ok = 1'b1;
`endif

   // State register.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic, handshake and framing decisions.
   always_comb begin
      state_d   = state_q;
      cfg_ready = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      start_ok  = 1'b0;
      err_set   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            cfg_ready = 1'b1;
            busy      = 1'b1;
            if (cfg_valid) begin
               accept = 1'b1;
               if (parity_ok) begin
                  state_d = S_WRITE;
               end else begin
                  // A corrupted word is never written into the fabric.
                  err_set = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WRITE: begin
            busy = 1'b1;
            if (last_q && (frame_cnt == FRAME_LAST)) begin
               if (SETTLE_CYCLES == 0) state_d = S_ENABLE;
               else                    state_d = S_SETTLE;
            end else if (last_q || (frame_cnt == FRAME_LAST)) begin
               // Early last or missing last: abandon with fabric disabled.
               err_set = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_SETTLE: begin
            busy = 1'b1;
            if (settle_cnt == SET_LAST) state_d = S_ENABLE;
         end
         S_ENABLE: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Word capture, frame strobe, counters and status flags.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         configs_in <= '0;
         configs_en <= '0;
         last_q     <= 1'b0;
         frame_cnt  <= '0;
         settle_cnt <= '0;
         err        <= 1'b0;
         ff_en      <= 1'b0;
         rdy        <= 1'b0;
      end else begin
         // Strobe is raised only for the single WRITE cycle after an accept.
         if (accept && parity_ok) configs_en <= EN_ONE << frame_cnt;
         else                     configs_en <= '0;

         if (accept) begin
            configs_in <= cfg_data;
            last_q     <= cfg_last;
         end

         if (start_ok)                frame_cnt <= '0;
         else if (state_q == S_WRITE) frame_cnt <= frame_cnt + CNT_W'(1);

         if (state_q == S_SETTLE) settle_cnt <= settle_cnt + SET_W'(1);
         else                     settle_cnt <= '0;

         if (start_ok)     err <= 1'b0;
         else if (err_set) err <= 1'b1;

         // Registered from the next state so ff_en leads rdy by one cycle
         // and both drop on the edge that accepts a reconfiguration start.
         ff_en <= (state_d == S_ENABLE) || (state_d == S_DONE);
         rdy   <= (state_d == S_DONE);
      end
   end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader with a small fabric (4 frames,
// 2 settle cycles). Frame strobes are checked by a scoreboard monitor;
// status/timing checks are made inline by the stimulus process.
module tb_fpga_cfg_loader;

   localparam int CFG_W = 8;
   localparam int NF    = 4;
   localparam int SC    = 2;
   localparam int CW    = 3;

   logic             clock = 1'b0;
   logic             rst;
   logic             start;
   logic [CFG_W-1:0] cfg_data;
   logic             cfg_valid;
   logic             cfg_last;
   logic             cfg_parity;
   logic             cfg_ready;
   logic [CFG_W-1:0] configs_in;
   logic [NF-1:0]    configs_en;
   logic             ff_en;
   logic             rdy;
   logic             busy;
   logic [CW-1:0]    frame_cnt;
   logic             err;

   always #5 clock = ~clock;

   fpga_cfg_loader #(
      .CFG_W(CFG_W), .NUM_FRAMES(NF), .SETTLE_CYCLES(SC), .CNT_W(CW)
   ) dut (
      .clock(clock), .rst(rst), .start(start),
      .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_last(cfg_last),
`ifdef CFG_PARITY_EN
      .cfg_parity(cfg_parity),
`endif
      .cfg_ready(cfg_ready), .configs_in(configs_in), .configs_en(configs_en),
      .ff_en(ff_en), .rdy(rdy), .busy(busy), .frame_cnt(frame_cnt), .err(err)
   );

   int vec_cnt  = 0;
   int miss_cnt = 0;

   logic [NF-1:0]    exp_en_q[$];
   logic [CFG_W-1:0] exp_data_q[$];
   logic [NF-1:0]    mon_en;
   logic [CFG_W-1:0] mon_data;

   // Monitor: every strobe the DUT presents must match the next expected one.
   always @(negedge clock) begin
      if (configs_en != '0) begin
         vec_cnt++;
         if (exp_en_q.size() == 0) begin
            miss_cnt++;
            $display("FAIL strobe_unexpected: got en=%b data=%h, expected no strobe",
                     configs_en, configs_in);
         end else begin
            mon_en   = exp_en_q.pop_front();
            mon_data = exp_data_q.pop_front();
            if (configs_en !== mon_en || configs_in !== mon_data) begin
               miss_cnt++;
               $display("FAIL strobe: got en=%b data=%h, expected en=%b data=%h",
                        configs_en, configs_in, mon_en, mon_data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Present one word and wait (bounded) for it to be accepted. On return the
   // accept edge has passed, i.e. the DUT is in the cycle after the accept.
   task automatic send_word(input logic [CFG_W-1:0] data, input logic last,
                            input logic good_par, input logic push, input int idx);
      logic [NF-1:0] en;
      int n;
      cfg_data   = data;
      cfg_last   = last;
      cfg_parity = good_par ? ^data : ~^data;
      cfg_valid  = 1'b1;
      n = 0;
      while (!cfg_ready && n < 20) begin
         step();
         n++;
      end
      if (!cfg_ready) begin
         vec_cnt++;
         miss_cnt++;
         $display("FAIL accept_timeout: got cfg_ready=0, expected 1 within 20 cycles");
      end else begin
         if (push) begin
            en = '0;
            en[idx] = 1'b1;
            exp_en_q.push_back(en);
            exp_data_q.push_back(data);
         end
         step();
      end
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   task automatic load_rest(input logic [CFG_W-1:0] base, input int first);
      for (int i = first; i < NF; i++)
         send_word(base + CFG_W'(i), (i == NF - 1), 1'b1, 1'b1, i);
   endtask

   // Called in the WRITE cycle of the final frame.
   task automatic check_completion(input string tag);
      step();
      chk({tag, "_ff_en_settle1"}, ff_en, 0);
      step();
      chk({tag, "_ff_en_settle2"}, ff_en, 0);
      step();
      chk({tag, "_ff_en_rise"}, ff_en, 1);
      chk({tag, "_rdy_lag"}, rdy, 0);
      step();
      chk({tag, "_rdy_rise"}, rdy, 1);
      chk({tag, "_ff_en_hold"}, ff_en, 1);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_frame_cnt"}, frame_cnt, NF);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; cfg_data = '0; cfg_valid = 1'b0;
      cfg_last = 1'b0; cfg_parity = 1'b0;
      step();
      step();
      chk("rst_configs_in", configs_in, 0);
      chk("rst_configs_en", configs_en, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_flags", {err, ff_en, rdy, busy, cfg_ready}, 0);
      rst = 1'b1;
      step();

      // Nominal load
      pulse_start();
      chk("t1_busy", busy, 1);
      chk("t1_ready", cfg_ready, 1);
      load_rest(8'hA0, 0);
      check_completion("t1");

      // Source stall after the first word
      pulse_start();
      chk("t2_ff_en_drop", ff_en, 0);
      send_word(8'hB0, 1'b0, 1'b1, 1'b1, 0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t2_stall_ready", cfg_ready, 1);
         chk("t2_stall_cnt", frame_cnt, 1);
         step();
      end
      load_rest(8'hB0, 1);
      check_completion("t2");

      // Early last on word 2
      pulse_start();
      send_word(8'hC0, 1'b0, 1'b1, 1'b1, 0);
      send_word(8'hC1, 1'b1, 1'b1, 1'b1, 1);
      step();
      chk("t3a_err", err, 1);
      chk("t3a_ff_en", ff_en, 0);
      chk("t3a_frame_cnt", frame_cnt, 2);
      chk("t3a_idle", {busy, cfg_ready}, 0);
      // Valid words presented in IDLE must not be consumed
      cfg_valid = 1'b1; cfg_data = 8'hEE;
      repeat (3) step();
      cfg_valid = 1'b0;
      chk("t3a_idle_ignore", frame_cnt, 2);

      // Missing last on word 4
      pulse_start();
      chk("t3b_err_clear", err, 0);
      for (int i = 0; i < NF; i++)
         send_word(8'hD0 + CFG_W'(i), 1'b0, 1'b1, 1'b1, i);
      step();
      chk("t3b_err", err, 1);
      chk("t3b_ff_en", ff_en, 0);
      chk("t3b_frame_cnt", frame_cnt, NF);
      chk("t3b_busy", busy, 0);

      // Reset in the middle of a load
      pulse_start();
      send_word(8'hE0, 1'b0, 1'b1, 1'b1, 0);
      send_word(8'hE1, 1'b0, 1'b1, 1'b0, 1);
      chk("t4_pre_en", configs_en, 4'b0010);
      #2 rst = 1'b0;
      #1;
      chk("t4_async_en", configs_en, 0);
      chk("t4_async_in", configs_in, 0);
      chk("t4_async_cnt", frame_cnt, 0);
      chk("t4_async_flags", {err, ff_en, rdy, busy, cfg_ready}, 0);
      repeat (3) step();
      rst = 1'b1;
      step();
      pulse_start();
      load_rest(8'hF0, 0);
      check_completion("t4");

      // Reconfiguration from DONE, start ignored while loading
      pulse_start();
      chk("t5_drop", {ff_en, rdy}, 0);
      chk("t5_busy", busy, 1);
      send_word(8'h50, 1'b0, 1'b1, 1'b1, 0);
      step();
      pulse_start();
      chk("t5_start_ignored_cnt", frame_cnt, 1);
      chk("t5_start_ignored_ready", cfg_ready, 1);
      load_rest(8'h50, 1);
      check_completion("t5");

`ifdef CFG_PARITY_EN
      // Bad parity on word 3
      pulse_start();
      send_word(8'h60, 1'b0, 1'b1, 1'b1, 0);
      send_word(8'h61, 1'b0, 1'b1, 1'b1, 1);
      send_word(8'h62, 1'b0, 1'b0, 1'b0, 2);
      chk("t6_err", err, 1);
      chk("t6_frame_cnt", frame_cnt, 2);
      chk("t6_idle", {busy, cfg_ready}, 0);
      chk("t6_no_strobe", configs_en, 0);
      step();
`endif

      step();
      chk("strobes_outstanding", exp_en_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
